// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
interface mult_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, overflow
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, overflow
  );
endinterface

// File: rtl/seq_multiplier.sv
// Fixed-latency shift-and-add multiplier: one multiplier bit per BUSY cycle,
// signed operands handled as magnitudes with a final conditional negate.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_mcand, r_acc, r_product;
  logic            r_neg, r_sgn, r_overflow;

  logic            w_accept, w_last, w_sgn, w_ovf;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [PW-1:0]   w_acc_nxt, w_res;

  assign w_sgn   = SIGNED_EN & bus.signed_mode;
  // Negating the most negative value wraps to itself, which read unsigned is
  // exactly its magnitude.
  assign w_mag_a = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_res     = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_ovf     = r_sgn ? !((&w_res[PW-1:WIDTH-1]) || !(|w_res[PW-1:WIDTH-1]))
                           : (|w_res[PW-1:WIDTH]);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.in_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_mplier   <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_sgn      <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_neg    <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_sgn    <= w_sgn;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_product  <= w_res;
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = r_product;
  assign bus.overflow  = r_overflow;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 Parameter SIGNED_EN, default 1; when 0, the signed_mode input is ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1: two's-complement operands; 0: unsigned.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 product  output  2*WIDTH  full-width product.
REQ-013 overflow  output  1  product does not fit in WIDTH bits.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 An operation SHALL be accepted on an edge where in_valid=1 and in_ready=1; a, b and signed_mode are captured and the state goes to BUSY.
REQ-017 BUSY SHALL last exactly WIDTH cycles, processing one multiplier bit per cycle by shift-and-add, LSB first.
REQ-018 On the WIDTH-th BUSY edge, product and overflow SHALL be registered and the state goes to DONE; out_valid is first high in the cycle after that edge (WIDTH+1 cycles after the accept edge).
REQ-019 Signed mode SHALL multiply operand magnitudes, then negate the result if the operand signs differ; the most negative value SHALL be handled correctly (e.g. WIDTH=8: -128 * -128 = 16384).
REQ-020 product SHALL be exact modulo 2^(2*WIDTH); product[WIDTH-1:0] SHALL equal the truncated WIDTH-bit product.
REQ-021 overflow, unsigned mode: SHALL be 1 when product[2W-1:W] != 0.
REQ-022 overflow, signed mode: SHALL be 1 when product[2W-1:W-1] is not all-0 and not all-1.
REQ-023 In DONE, product and overflow SHALL remain stable until out_ready=1; on an edge with out_ready=1 the state SHALL go to IDLE.
REQ-024 DONE to IDLE takes one edge; a new operation cannot be accepted on the same edge (in_ready=0 in DONE).
REQ-025 in_valid SHALL be ignored while in BUSY or DONE, and input changes during BUSY SHALL NOT affect the result.
REQ-026 Operand zero SHALL still take the full WIDTH BUSY cycles (fixed latency, no early termination).

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, product=0, overflow=0 and clear internal counters and accumulators.
REQ-028 Reset during BUSY or DONE SHALL abort the operation without producing any result.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-030 A shared package mult_pkg SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-031 The bit counter width SHALL be $clog2(WIDTH+1), defined locally.
REQ-032 The design SHALL be a single module with no sub-module; negation and magnitude logic stay inline.

Verification
REQ-033 WIDTH=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, overflow=1, out_valid at cycle 33 after accept.
REQ-034 WIDTH=8, signed, a=-3 (0xFD), b=7 -> product=0xFFEB (-21), overflow=0; a=-128, b=-128 -> product=0x4000, overflow=1.
REQ-035 WIDTH=8, unsigned, a=16, b=16; hold out_ready=0 for 5 cycles -> product=0x0100, overflow=1, and outputs stay stable until out_ready=1.
REQ-036 Assert rst_n=0 mid-BUSY on cycle 4 -> out_valid stays 0 and in_ready=1 immediately; a following 5*6 returns 30.
REQ-037 Apply in_valid continuously with changing operands -> only operands sampled on accept edges are used; one result per accept, with a throughput of one operation per WIDTH+2 cycles.
REQ-038 SIGNED_EN=0, signed_mode=1, WIDTH=8, a=0xFF, b=0x02 -> product=0x01FE (unsigned result).
